// File: rtl/ex_muldiv_unit_if.sv
// EX-stage multiply/divide bus: operand/op request from the pipeline, stall and HI/LO back.
// The MULDIV_FAST_MUL_EN build option is handled inside ex_muldiv_unit; this bundle is width-only.
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    // Handshake: start_i is a level held by EX for as long as the instruction sits there.
    // The instruction may leave EX on any cycle where stall_o is low; a multi-cycle op
    // keeps stall_o high from its first cycle until the DONE cycle, when HI/LO are valid.
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             stall_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  stall_o, busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output stall_o, busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with single-cycle MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational MULT/MULTU.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_muldiv_unit_if.slave bus,
    output logic [1:0]     stateDbg
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hiReg, loReg;
    logic [WIDTH-1:0] accHi, accLo, opnd;
    logic             isDivR, negQ, negR;

    logic             isMulOp, isDivOp, isSigned, longOp, accept;
    logic             aNeg, bNeg, divZeroIn;
    logic [WIDTH-1:0] magA, magB;

    always_comb begin
        isMulOp   = (bus.op_i == OP_MULT) || (bus.op_i == OP_MULTU);
        isDivOp   = (bus.op_i == OP_DIV)  || (bus.op_i == OP_DIVU);
        isSigned  = ~bus.op_i[0];
`ifdef MULDIV_FAST_MUL_EN
        longOp    = isDivOp;
`else
        longOp    = isMulOp || isDivOp;
`endif
        accept    = (state == IDLE) && bus.start_i && !bus.flush_i;
        aNeg      = isSigned && bus.a_i[WIDTH-1];
        bNeg      = isSigned && bus.b_i[WIDTH-1];
        magA      = aNeg ? (~bus.a_i + 1'b1) : bus.a_i;
        magB      = bNeg ? (~bus.b_i + 1'b1) : bus.b_i;
        divZeroIn = isDivOp && (bus.b_i == '0);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*WIDTH-1:0] sProd;
    logic        [2*WIDTH-1:0] uProd, fastProd;
    always_comb begin
        sProd    = $signed({{WIDTH{bus.a_i[WIDTH-1]}}, bus.a_i}) *
                   $signed({{WIDTH{bus.b_i[WIDTH-1]}}, bus.b_i});
        uProd    = {{WIDTH{1'b0}}, bus.a_i} * {{WIDTH{1'b0}}, bus.b_i};
        fastProd = isSigned ? sProd : uProd;
    end
`endif

    // One iteration: shift-add (multiplier in accLo) or restoring shift-subtract (dividend in accLo).
    logic [WIDTH:0]     mulSum, divShift, divTrial;
    logic               divFit;
    logic [WIDTH-1:0]   stepHi, stepLo, quoFix, remFix, finalHi, finalLo;
    logic [2*WIDTH-1:0] prodFix;

    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
        divShift = {accHi, accLo[WIDTH-1]};
        divTrial = divShift - {1'b0, opnd};
        divFit   = ~divTrial[WIDTH];
        if (isDivR) begin
            stepHi = divFit ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
            stepLo = {accLo[WIDTH-2:0], divFit};
        end else begin
            stepHi = mulSum[WIDTH:1];
            stepLo = {mulSum[0], accLo[WIDTH-1:1]};
        end
        prodFix = negQ ? (~{stepHi, stepLo} + 1'b1) : {stepHi, stepLo};
        quoFix  = negQ ? (~stepLo + 1'b1) : stepLo;
        remFix  = negR ? (~stepHi + 1'b1) : stepHi;
        finalHi = isDivR ? remFix : prodFix[2*WIDTH-1:WIDTH];
        finalLo = isDivR ? quoFix : prodFix[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            hiReg  <= '0;
            loReg  <= '0;
            accHi  <= '0;
            accLo  <= '0;
            opnd   <= '0;
            isDivR <= 1'b0;
            negQ   <= 1'b0;
            negR   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (longOp) begin
                            // A zero divisor runs unsigned on the raw dividend so HI ends up as a_i.
                            accHi  <= '0;
                            accLo  <= divZeroIn ? bus.a_i : magA;
                            opnd   <= magB;
                            isDivR <= isDivOp;
                            negQ   <= (aNeg ^ bNeg) && !divZeroIn;
                            negR   <= aNeg && isDivOp && !divZeroIn;
                            count  <= '0;
                            state  <= RUN;
                        end else if (bus.op_i == OP_MTHI) begin
                            hiReg <= bus.a_i;
                        end else if (bus.op_i == OP_MTLO) begin
                            loReg <= bus.a_i;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (isMulOp) begin
                            hiReg <= fastProd[2*WIDTH-1:WIDTH];
                            loReg <= fastProd[WIDTH-1:0];
                        end
`endif
                    end
                end
                RUN: begin
                    if (bus.flush_i) begin
                        state <= IDLE;
                    end else begin
                        accHi <= stepHi;
                        accLo <= stepLo;
                        count <= count + 1'b1;
                        if (count == CW'(WIDTH - 1)) begin
                            hiReg <= finalHi;
                            loReg <= finalLo;
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall_o = (accept && longOp) || (state == RUN);
    assign bus.busy_o  = (state == RUN);
    assign bus.done_o  = (state == DONE);
    assign bus.hi_o    = hiReg;
    assign bus.lo_o    = loReg;
    assign stateDbg    = state;
endmodule
